// File: rtl/audio_stream_sequencer_pkg.sv
// audio_pkg: shared FSM states, audio ring addresses and DAC word formatting
package audio_pkg;
    typedef enum logic [2:0] {IDLE, READ, WAIT_RD, DAC, GAP, ADC, WRITE} state_e;
    localparam logic [15:0] MEM_AUDIO_FIRST  = 16'hC000;
    localparam logic [15:0] MEM_AUDIO_SECOND = 16'hE000;
    localparam logic [15:0] MEM_AUDIO_LAST   = 16'hFFFE;
    function automatic logic [15:0] dac_format(logic [15:0] d);
        return {4'd0, d[15:6], 2'd0};
    endfunction
endpackage

// File: rtl/audio_stream_sequencer_if.sv
// audio_stream_sequencer_if: RAM port B, DAC/ADC serial lines and status towards MMIO
interface audio_stream_sequencer_if;
    logic        enable;
    logic [14:0] ram_addr;
    logic        ram_en;
    logic [1:0]  ram_wr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        dac_cs;
    logic        dac_mosi;
    logic        adc_cs;
    logic        adc_miso;
    logic        free_half;
    logic        half_swap;
    logic        overrun;
    logic        busy;
    modport master (
        input  enable, ram_dout, adc_miso,
        output ram_addr, ram_en, ram_wr, ram_din, dac_cs, dac_mosi, adc_cs,
               free_half, half_swap, overrun, busy
    );
    modport slave (
        output enable, ram_dout, adc_miso,
        input  ram_addr, ram_en, ram_wr, ram_din, dac_cs, dac_mosi, adc_cs,
               free_half, half_swap, overrun, busy
    );
endinterface

// File: rtl/audio_stream_sequencer_spi.sv
// spi_word_shifter: 16-bit MSB-first shift register with load, serial in/out and active-low CS
module spi_word_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        active_i,
    input  logic        load_i,
    input  logic [15:0] data_i,
    input  logic        sin_i,
    output logic        cs_n_o,
    output logic        sout_o,
    output logic [15:0] word_o
);
    logic [15:0] word_q, word_d;
    always_comb word_d = load_i ? data_i : active_i ? {word_q[14:0], sin_i} : word_q;
    always_ff @(posedge clk) begin
        if (rst) word_q <= '0;
        else     word_q <= word_d;
    end
    assign cs_n_o = ~active_i;
    assign sout_o = active_i & word_q[15];
    assign word_o = word_q;
endmodule

// File: rtl/audio_stream_sequencer.sv
// audio_stream_sequencer: owns audio RAM port B; one read/DAC/ADC/write frame per sample period
module audio_stream_sequencer
    import audio_pkg::*;
#(
    parameter int          CLOCKS_PER_SAMPLE = 600,
    parameter int          READ_LATENCY      = 2,
    parameter logic [15:0] BUF_BASE          = MEM_AUDIO_FIRST,
    parameter logic [15:0] BUF_HALF          = MEM_AUDIO_SECOND,
    parameter logic [15:0] BUF_LAST          = MEM_AUDIO_LAST
) (
    input logic                      system_clock,
    input logic                      reset,
    audio_stream_sequencer_if.master bus
);
    localparam int TW = $clog2(CLOCKS_PER_SAMPLE);
    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [15:0]   ptr_q, ptr_d;
    logic          overrun_q, overrun_d, half_swap_q, half_swap_d;
    logic          start, dac_load;
    logic [15:0]   dac_word, adc_word;
    logic          adc_sout, unused_bits;
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            cnt_q       <= '0;
            ptr_q       <= BUF_BASE;
            overrun_q   <= 1'b0;
            half_swap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            overrun_q   <= overrun_d;
            half_swap_q <= half_swap_d;
        end
    end
    always_comb begin
        start     = bus.enable && tick_q == '0;
        tick_d    = (!bus.enable || tick_q == TW'(CLOCKS_PER_SAMPLE - 1)) ? '0 : tick_q + 1'b1;
        ptr_d     = ptr_q;
        overrun_d = overrun_q || (start && state_q != IDLE);
        state_d   = state_q;
        cnt_d     = cnt_q + 5'd1;
        dac_load  = state_q == WAIT_RD && cnt_q == 5'(READ_LATENCY - 1);
        case (state_q)
            IDLE:    if (start) begin state_d = READ; ptr_d = (ptr_q == BUF_LAST) ? BUF_BASE : ptr_q + 16'd2; end
            READ:    begin state_d = WAIT_RD; cnt_d = '0; end
            WAIT_RD: if (dac_load) begin state_d = DAC; cnt_d = '0; end
            DAC:     if (cnt_q == 5'd15) state_d = GAP;
            GAP:     begin state_d = ADC; cnt_d = '0; end
            ADC:     if (cnt_q == 5'd15) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        half_swap_d = (ptr_d >= BUF_HALF) != (ptr_q >= BUF_HALF);
    end
    spi_word_shifter u_dac (
        .clk(system_clock), .rst(reset), .active_i(state_q == DAC), .load_i(dac_load),
        .data_i(dac_format(bus.ram_dout)), .sin_i(1'b0),
        .cs_n_o(bus.dac_cs), .sout_o(bus.dac_mosi), .word_o(dac_word)
    );
    spi_word_shifter u_adc (
        .clk(system_clock), .rst(reset), .active_i(state_q == ADC), .load_i(1'b0),
        .data_i(16'd0), .sin_i(bus.adc_miso),
        .cs_n_o(bus.adc_cs), .sout_o(adc_sout), .word_o(adc_word)
    );
    // the address is only presented while the port is enabled so it idles at zero
    assign bus.ram_en    = state_q == READ || state_q == WRITE;
    assign bus.ram_wr    = {2{state_q == WRITE}};
    assign bus.ram_addr  = bus.ram_en ? ptr_q[15:1] : 15'd0;
    assign bus.ram_din   = (state_q == WRITE) ? {adc_word[11:4], 8'd0} : 16'd0;
    assign bus.free_half = ptr_q >= BUF_HALF;
    assign bus.half_swap = half_swap_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = state_q != IDLE;
    assign unused_bits   = ^{dac_word, adc_word[15:12], adc_word[3:0], adc_sout, ptr_q[0]};
endmodule

// File: tb/tb_audio_stream_sequencer.sv
// tb_audio_stream_sequencer: directed checks of frame timing, half swaps, overrun and reset abort
module tb_audio_stream_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_m, rst_h, rst_o;
    int vectors = 0;
    int errors = 0;
    audio_stream_sequencer_if m_if ();
    audio_stream_sequencer_if h_if ();
    audio_stream_sequencer_if o_if ();
    audio_stream_sequencer dut (.system_clock(clk), .reset(rst_m), .bus(m_if));
    // small ring straddling the half boundary so both swap directions occur within a few frames
    audio_stream_sequencer #(.CLOCKS_PER_SAMPLE(40), .BUF_BASE(16'hDFFC), .BUF_HALF(16'hE000),
                             .BUF_LAST(16'hE002)) dut_h (.system_clock(clk), .reset(rst_h), .bus(h_if));
    audio_stream_sequencer #(.CLOCKS_PER_SAMPLE(30)) dut_o (.system_clock(clk), .reset(rst_o), .bus(o_if));

    logic [15:0] adc_word = 16'h0AB0;
    int adc_k = 0;
    always @(negedge clk) begin
        if (m_if.adc_cs) begin
            adc_k = 0;
            m_if.adc_miso = 1'b0;
        end else if (adc_k < 16) begin
            m_if.adc_miso = adc_word[15 - adc_k];
            adc_k++;
        end
    end

    task automatic test_reset();
        logic [39:0] got;
        rst_m = 1; rst_h = 1; rst_o = 1;
        m_if.enable = 0; m_if.ram_dout = 16'hFFC0;
        h_if.enable = 0; h_if.ram_dout = 16'h0; h_if.adc_miso = 0;
        o_if.enable = 0; o_if.ram_dout = 16'h0; o_if.adc_miso = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {m_if.ram_en, m_if.ram_wr, m_if.ram_addr, m_if.ram_din, m_if.dac_cs, m_if.dac_mosi,
               m_if.adc_cs, m_if.half_swap, m_if.overrun, m_if.busy};
        vectors++;
        if (got !== {1'b0, 2'b00, 15'd0, 16'd0, 1'b1, 1'b0, 1'b1, 3'b000}) begin
            errors++; $display("FAIL reset_outputs got %h want %h", got, {1'b0, 2'b00, 15'd0, 16'd0, 1'b1, 1'b0, 1'b1, 3'b000});
        end
        vectors++;
        if (dut.ptr_q !== 16'hC000) begin errors++; $display("FAIL reset_pointer got %h want c000", dut.ptr_q); end
        vectors++;
        if (dut.tick_q !== '0) begin errors++; $display("FAIL reset_tick got %0d want 0", dut.tick_q); end
        vectors++;
        if (m_if.free_half !== 1'b0) begin errors++; $display("FAIL reset_free_half got %b want 0", m_if.free_half); end
    endtask

    task automatic test_dac_adc_frame();
        logic [15:0] bits = '0;
        int low = 0, cyc = 0, en_mid = 0;
        logic mosi_idle = 1'b0;
        rst_m = 0; m_if.enable = 1;
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({m_if.ram_en, m_if.ram_wr, m_if.ram_addr} !== {1'b1, 2'b00, 15'h6001}) begin
            errors++; $display("FAIL read_cycle got en=%b wr=%b addr=%h want en=1 wr=00 addr=6001", m_if.ram_en, m_if.ram_wr, m_if.ram_addr);
        end
        vectors++;
        if (dut.tick_q !== 10'd1) begin errors++; $display("FAIL read_tick got %0d want 1", dut.tick_q); end
        while (!(m_if.ram_en && m_if.ram_wr == 2'b11) && cyc < 100) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (!m_if.dac_cs) begin bits = {bits[14:0], m_if.dac_mosi}; low++; end
            else if (m_if.dac_mosi) mosi_idle = 1'b1;
            if (m_if.ram_en && m_if.ram_wr != 2'b11) en_mid++;
        end
        vectors++;
        if (cyc !== 36) begin errors++; $display("FAIL write_latency got %0d want 36", cyc); end
        vectors++;
        if (bits !== 16'h0FFC) begin errors++; $display("FAIL dac_stream got %h want 0ffc", bits); end
        vectors++;
        if (low !== 16) begin errors++; $display("FAIL dac_cs_low got %0d want 16", low); end
        vectors++;
        if (mosi_idle !== 1'b0) begin errors++; $display("FAIL dac_mosi_idle got %b want 0", mosi_idle); end
        vectors++;
        if (en_mid !== 0) begin errors++; $display("FAIL ram_en_mid_frame got %0d want 0", en_mid); end
        vectors++;
        if ({m_if.ram_addr, m_if.ram_din} !== {15'h6001, 16'hAB00}) begin
            errors++; $display("FAIL write_cycle got addr=%h din=%h want addr=6001 din=ab00", m_if.ram_addr, m_if.ram_din);
        end
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({m_if.busy, m_if.ram_en} !== 2'b00) begin errors++; $display("FAIL frame_end got busy=%b en=%b want 0 0", m_if.busy, m_if.ram_en); end
    endtask

    task automatic test_reset_mid_dac();
        int cyc = 0;
        while (m_if.dac_cs !== 1'b0 && cyc < 700) begin @(posedge clk); @(negedge clk); cyc++; end
        vectors++;
        if (cyc >= 700) begin errors++; $display("FAIL second_frame_timeout got %0d cycles want <700", cyc); end
        vectors++;
        if (dut.ptr_q !== 16'hC004) begin errors++; $display("FAIL second_frame_pointer got %h want c004", dut.ptr_q); end
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst_m = 1;
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({m_if.dac_cs, m_if.ram_en, m_if.busy, m_if.dac_mosi} !== 4'b1000) begin
            errors++; $display("FAIL abort_outputs got cs=%b en=%b busy=%b mosi=%b want 1 0 0 0", m_if.dac_cs, m_if.ram_en, m_if.busy, m_if.dac_mosi);
        end
        vectors++;
        if (dut.ptr_q !== 16'hC000) begin errors++; $display("FAIL abort_pointer got %h want c000", dut.ptr_q); end
        m_if.enable = 0;
        rst_m = 0;
    endtask

    task automatic test_half_swap();
        logic [15:0] exp_ptr [4] = '{16'hDFFE, 16'hE000, 16'hE002, 16'hDFFC};
        logic        exp_fh  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          exp_sw  [4] = '{0, 1, 0, 1};
        logic [15:0] got_ptr [4] = '{default: 16'h0};
        logic        got_fh  [4] = '{default: 1'bx};
        int          got_sw  [4] = '{default: 0};
        int frame = 0;
        rst_h = 0; h_if.enable = 1;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); @(negedge clk);
            if (h_if.ram_en && h_if.ram_wr == 2'b00) begin
                if (frame < 4) begin got_ptr[frame] = {h_if.ram_addr, 1'b0}; got_fh[frame] = h_if.free_half; end
                frame++;
            end
            if (h_if.half_swap && frame > 0 && frame <= 4) got_sw[frame - 1]++;
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_ptr[i] !== exp_ptr[i]) begin errors++; $display("FAIL swap_ptr[%0d] got %h want %h", i, got_ptr[i], exp_ptr[i]); end
            vectors++;
            if (got_fh[i] !== exp_fh[i]) begin errors++; $display("FAIL swap_free_half[%0d] got %b want %b", i, got_fh[i], exp_fh[i]); end
            vectors++;
            if (got_sw[i] !== exp_sw[i]) begin errors++; $display("FAIL swap_pulses[%0d] got %0d want %0d", i, got_sw[i], exp_sw[i]); end
        end
    endtask

    task automatic test_overrun();
        int reads = 0;
        rst_o = 0; o_if.enable = 1;
        for (int c = 0; c < 130; c++) begin
            @(posedge clk); @(negedge clk);
            if (o_if.ram_en && o_if.ram_wr == 2'b00) reads++;
            if (c == 29) begin
                vectors++;
                if (o_if.overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got %b want 0", o_if.overrun); end
            end
            if (c == 30) begin
                vectors++;
                if ({o_if.overrun, o_if.busy} !== 2'b11) begin errors++; $display("FAIL overrun_set got ovr=%b busy=%b want 1 1", o_if.overrun, o_if.busy); end
                vectors++;
                if (dut_o.ptr_q !== 16'hC002) begin errors++; $display("FAIL overrun_skip_ptr got %h want c002", dut_o.ptr_q); end
            end
        end
        vectors++;
        if (reads !== 3) begin errors++; $display("FAIL overrun_frames got %0d want 3", reads); end
        vectors++;
        if (dut_o.ptr_q !== 16'hC006) begin errors++; $display("FAIL overrun_final_ptr got %h want c006", dut_o.ptr_q); end
    endtask

    initial begin
        test_reset();
        test_dac_adc_frame();
        test_reset_mid_dac();
        test_half_swap();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
